// File: rtl/counter_cascade_disp.sv
// High-order digit stage behind the bounded up/down counter, plus a two-digit
// multiplexed 7-segment driver that shows the incoming low digit and the high digit.
module counter_cascade_disp #(
   parameter int HI_MAX   = 9,
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr,
   input  logic [3:0] Q_in,
   input  logic       carry_in,
   input  logic       dir,
   output logic [3:0] hi_q,
   output logic       hi_carry,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int              SCAN_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [3:0]      HI_TOP    = 4'(HI_MAX);

   typedef enum logic {
      DIGIT_LO = 1'b0,
      DIGIT_HI = 1'b1
   } digit_t;

   logic              r_carryPrev;
   logic [3:0]        r_hiQ;
   logic              r_hiCarry;
   logic [SCAN_W-1:0] r_scanCnt;
   digit_t            r_sel;
   logic [6:0]        r_seg;
   logic [1:0]        r_an;

   logic              w_evt;
   logic [3:0]        w_hiNext;
   logic              w_hiCarryNext;
   logic              w_scanWrap;
   logic [SCAN_W-1:0] w_scanNext;
   digit_t            w_selNext;
   logic [3:0]        w_dispDigit;
   logic [6:0]        w_segNext;
   logic [1:0]        w_anNext;

   function automatic logic [6:0] hexSeg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // A held carry level counts once; clear wins over a simultaneous carry event.
   assign w_evt = carry_in & ~r_carryPrev;

   always_comb begin
      w_hiNext      = r_hiQ;
      w_hiCarryNext = 1'b0;
      if (clr) begin
         w_hiNext = 4'd0;
      end else if (w_evt) begin
         if (!dir) begin
            if (r_hiQ == HI_TOP) begin
               w_hiNext      = 4'd0;
               w_hiCarryNext = 1'b1;
            end else begin
               w_hiNext = r_hiQ + 4'd1;
            end
         end else begin
            if (r_hiQ == 4'd0) begin
               w_hiNext      = HI_TOP;
               w_hiCarryNext = 1'b1;
            end else begin
               w_hiNext = r_hiQ - 4'd1;
            end
         end
      end
   end

   always_comb begin
      w_scanWrap = (r_scanCnt == SCAN_LAST);
      w_scanNext = w_scanWrap ? '0 : r_scanCnt + SCAN_W'(1);
      w_selNext  = r_sel;
      if (w_scanWrap) begin
         w_selNext = (r_sel == DIGIT_LO) ? DIGIT_HI : DIGIT_LO;
      end
   end

   always_comb begin
      w_dispDigit = (r_sel == DIGIT_HI) ? r_hiQ : Q_in;
      w_segNext   = hexSeg(w_dispDigit);
      w_anNext    = (r_sel == DIGIT_HI) ? 2'b01 : 2'b10;
   end

   // carry_prev resets high so a carry held through reset release is not counted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_carryPrev <= 1'b1;
         r_hiQ       <= 4'd0;
         r_hiCarry   <= 1'b0;
         r_scanCnt   <= '0;
         r_sel       <= DIGIT_LO;
         r_seg       <= 7'h00;
         r_an        <= 2'b11;
      end else begin
         r_carryPrev <= carry_in;
         r_hiQ       <= w_hiNext;
         r_hiCarry   <= w_hiCarryNext;
         r_scanCnt   <= w_scanNext;
         r_sel       <= w_selNext;
         r_seg       <= w_segNext;
         r_an        <= w_anNext;
      end
   end

   assign hi_q     = r_hiQ;
   assign hi_carry = r_hiCarry;
   assign seg      = r_seg;
   assign an       = r_an;

endmodule
